// File: rtl/round_sequencer.sv
// Game phase controller: title -> intro wait -> timed play -> result wait -> next level / over / win.
// Optional macro EARLY_CLEAR_EN ends a round as soon as the score reaches the target.
module round_sequencer #(
    parameter int CLK_HZ        = 50000000,
    parameter int ROUND_SECONDS = 60,
    parameter int BASE_TARGET   = 650,
    parameter int TARGET_STEP   = 275,
    parameter int MAX_LEVEL     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_key,
    input  logic [15:0] score,
    input  logic        done_5sec,
    output logic        enable_5sec,
    output logic        round_active,
    output logic [3:0]  level,
    output logic [15:0] target,
    output logic [6:0]  time_left,
    output logic [2:0]  phase,
    output logic        game_over,
    output logic        win
);

    localparam int                TICK_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(CLK_HZ - 1);
    localparam logic [6:0]        ROUND_INIT  = 7'(ROUND_SECONDS);
    localparam logic [15:0]       TARGET_INIT = 16'(BASE_TARGET);
    localparam logic [15:0]       STEP        = 16'(TARGET_STEP);
    localparam logic [3:0]        LEVEL_LAST  = 4'(MAX_LEVEL);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INTRO  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_RESULT = 3'd3,
        ST_OVER   = 3'd4,
        ST_WIN    = 3'd5
    } phase_t;

    phase_t            state;
    logic [TICK_W-1:0] tick;
    logic              start_q;
    logic              armed;
    logic              pass;
    logic              start_edge;
    logic              done_ok;
    logic              second_tick;
    logic              reach_target;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // The counter's done stays high after a finished wait; only trust it once enable has been high a full cycle.
    assign start_edge   = start_key & ~start_q;
    assign done_ok      = done_5sec & armed & enable_5sec;
    assign second_tick  = (tick == TICK_LAST);
    assign reach_target = (score >= target);
    assign phase        = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            level        <= 4'd1;
            target       <= TARGET_INIT;
            time_left    <= ROUND_INIT;
            enable_5sec  <= 1'b0;
            round_active <= 1'b0;
            game_over    <= 1'b0;
            win          <= 1'b0;
            tick         <= '0;
            armed        <= 1'b0;
            start_q      <= 1'b0;
            pass         <= 1'b0;
        end else begin
            start_q <= start_key;
            armed   <= enable_5sec;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state       <= ST_INTRO;
                        enable_5sec <= 1'b1;
                    end
                end
                ST_INTRO: begin
                    if (done_ok) begin
                        state        <= ST_PLAY;
                        round_active <= 1'b1;
                        time_left    <= ROUND_INIT;
                        tick         <= '0;
                        enable_5sec  <= 1'b0;
                    end else begin
                        enable_5sec  <= 1'b1;
                    end
                end
                ST_PLAY: begin
`ifdef EARLY_CLEAR_EN
                    if (reach_target) begin
                        pass         <= 1'b1;
                        state        <= ST_RESULT;
                        round_active <= 1'b0;
                        enable_5sec  <= 1'b1;
                    end else
`endif
                    if (second_tick) begin
                        tick <= '0;
                        if (time_left <= 7'd1) begin
                            time_left    <= 7'd0;
                            pass         <= reach_target;
                            state        <= ST_RESULT;
                            round_active <= 1'b0;
                            enable_5sec  <= 1'b1;
                        end else begin
                            time_left    <= time_left - 7'd1;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (done_ok) begin
                        // Enable drops here; INTRO re-raises it a cycle later so the counter restarts cleanly.
                        enable_5sec <= 1'b0;
                        if (!pass) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                        end else if (level == LEVEL_LAST) begin
                            state     <= ST_WIN;
                            win       <= 1'b1;
                        end else begin
                            state     <= ST_INTRO;
                            level     <= level + 4'd1;
                            target    <= sat_add16(target, STEP);
                        end
                    end else begin
                        enable_5sec <= 1'b1;
                    end
                end
                ST_OVER, ST_WIN: begin
                    if (start_edge) begin
                        state       <= ST_INTRO;
                        level       <= 4'd1;
                        target      <= TARGET_INIT;
                        game_over   <= 1'b0;
                        win         <= 1'b0;
                        enable_5sec <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    enable_5sec  <= 1'b0;
                    round_active <= 1'b0;
                    game_over    <= 1'b0;
                    win          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: game-level model pushes expected phase snapshots, a monitor pops on each change.
`timescale 1ns/1ps
module tb_round_sequencer;

    localparam int CLK_HZ  = 10;
    localparam int ROUND_S = 3;
    localparam int MAX_LVL = 2;
    localparam int BASE    = 650;
    localparam int STEP    = 275;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_key;
    logic [15:0] score;
    logic        done_5sec = 1'b0;
    logic        enable_5sec;
    logic        round_active;
    logic [3:0]  level;
    logic [15:0] target;
    logic [6:0]  time_left;
    logic [2:0]  phase;
    logic        game_over;
    logic        win;

    round_sequencer #(
        .CLK_HZ(CLK_HZ), .ROUND_SECONDS(ROUND_S), .BASE_TARGET(BASE),
        .TARGET_STEP(STEP), .MAX_LEVEL(MAX_LVL)
    ) dut (
        .clk(clk), .reset(reset), .start_key(start_key), .score(score),
        .done_5sec(done_5sec), .enable_5sec(enable_5sec), .round_active(round_active),
        .level(level), .target(target), .time_left(time_left), .phase(phase),
        .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ph;
        logic [3:0]  lv;
        logic [15:0] tg;
        logic [6:0]  tl;
        logic        ra;
        logic        go;
        logic        wn;
    } snap_t;

    snap_t exp_q[$];
    snap_t prev;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    intro_cyc = 0;
    int    intro_l = 20;
    int    m_level = 1;
    int    m_target = BASE;
    logic  mon_en = 1'b0;
    logic  noise_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // 5-second counter stand-in: done after next_len enabled cycles, lingers one cycle past the enable drop.
    int   next_len = 20;
    int   cur_len = 0;
    int   cnt = 0;
    logic en_d = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            en_d      <= 1'b0;
            cnt       <= 0;
            done_5sec <= 1'b0;
        end else begin
            en_d <= enable_5sec;
            if (enable_5sec) begin
                if (!en_d) begin
                    cnt     <= 1;
                    cur_len <= next_len;
                end else begin
                    cnt <= cnt + 1;
                    if (cnt >= cur_len) done_5sec <= 1'b1;
                end
            end else begin
                cnt <= 0;
            end
            if (!en_d) done_5sec <= 1'b0;
        end
    end

    function automatic snap_t model_snap(input int ph, input int lv, input int tg, input int tl);
        snap_t s;
        s.ph = 3'(ph);
        s.lv = 4'(lv);
        s.tg = 16'(tg);
        s.tl = (ph == 2 || ph == 3) ? 7'(tl) : 7'd0;
        s.ra = (ph == 2);
        s.go = (ph == 4);
        s.wn = (ph == 5);
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.ph = phase;
        s.lv = level;
        s.tg = target;
        s.tl = (phase == 3'd2 || phase == 3'd3) ? time_left : 7'd0;
        s.ra = round_active;
        s.go = game_over;
        s.wn = win;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic check_snap(input string name, input snap_t act, input snap_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ph=%0d lv=%0d tg=%0d tl=%0d ra/go/win=%b%b%b, want ph=%0d lv=%0d tg=%0d tl=%0d ra/go/win=%b%b%b (cycle %0d)",
                     name, act.ph, act.lv, act.tg, act.tl, act.ra, act.go, act.wn,
                     exp.ph, exp.lv, exp.tg, exp.tl, exp.ra, exp.go, exp.wn, cyc);
        end
    endtask

    // Monitor: every change of the visible game state must match the next expected snapshot.
    always @(negedge clk) begin
        snap_t cur;
        if (mon_en) begin
            cur = dut_snap();
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got ph=%0d lv=%0d tg=%0d tl=%0d, want no change (cycle %0d)",
                             cur.ph, cur.lv, cur.tg, cur.tl, cyc);
                end else begin
                    check_snap("phase_seq", cur, exp_q.pop_front());
                end
                if (cur.ph == 3'd1 && prev.ph != 3'd1) intro_cyc = cyc;
                prev = cur;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (noise_on) begin
`ifdef EARLY_CLEAR_EN
            score = 16'($urandom_range(0, m_target - 1));
`else
            score = 16'($urandom_range(0, 65535));
`endif
            start_key = 1'($urandom_range(0, 1));
        end
    endtask

    // kind 0: phase == val, 1: time_left == val, 2: phase != val
    task automatic wait_for(input int kind, input int val, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            step();
            if ((kind == 0 && phase == 3'(val)) || (kind == 1 && time_left == 7'(val)) ||
                (kind == 2 && phase != 3'(val))) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: got timeout after %0d cycles, want event", name, budget);
    endtask

    task automatic press_start(input int hold, input int len);
        exp_q.push_back(model_snap(1, 1, BASE, 0));
        m_level = 1;
        m_target = BASE;
        next_len = len;
        intro_l = len;
        start_key = 1'b0;
        step();
        start_key = 1'b1;
        step();
        check("start_to_intro", int'(phase), 1);
        check("start_enable", int'(enable_5sec), 1);
        repeat (hold - 1) step();
        check("no_double_advance", int'(phase), 1);
        start_key = 1'b0;
    endtask

    // One round from INTRO; fin is the score applied once time_left reaches clear_at.
    task automatic play_round(input int fin, input int clear_at, output int outcome);
        int lv, tg, nlv, ntg, end_tl, low_tl, last;
        bit pass, early;
        lv = m_level;
        tg = m_target;
        pass = (fin >= tg);
        early = 1'b0;
`ifdef EARLY_CLEAR_EN
        early = pass;
`endif
        end_tl = early ? clear_at : 0;
        low_tl = early ? clear_at : 1;
        for (int t = ROUND_S; t >= low_tl; t--) exp_q.push_back(model_snap(2, lv, tg, t));
        exp_q.push_back(model_snap(3, lv, tg, end_tl));
        if (pass && lv == MAX_LVL) begin
            outcome = 2; nlv = lv; ntg = tg;
            exp_q.push_back(model_snap(5, lv, tg, 0));
        end else if (pass) begin
            outcome = 0; nlv = lv + 1;
            ntg = (tg + STEP > 65535) ? 65535 : tg + STEP;
            exp_q.push_back(model_snap(1, nlv, ntg, 0));
        end else begin
            outcome = 1; nlv = lv; ntg = tg;
            exp_q.push_back(model_snap(4, lv, tg, 0));
        end
        score = 16'd0;
        wait_for(0, 2, 200, "reach_play");
        check_range("intro_len", cyc - intro_cyc, intro_l + 2, intro_l + 4);
        last = cyc;
        noise_on = 1'b1;
        for (int t = ROUND_S - 1; t >= clear_at; t--) begin
            wait_for(1, t, 30, "tick");
            check("tick_spacing", cyc - last, CLK_HZ);
            last = cyc;
        end
        noise_on = 1'b0;
        start_key = 1'b0;
        score = 16'(fin);
        next_len = $urandom_range(8, 20);
        if (!early) begin
            for (int t = clear_at - 1; t >= 1; t--) begin
                wait_for(1, t, 30, "tick");
                check("tick_spacing", cyc - last, CLK_HZ);
                last = cyc;
            end
        end
        wait_for(0, 3, 30, "reach_result");
        check("result_spacing", cyc - last, early ? 1 : CLK_HZ);
        repeat (3) step();
        next_len = $urandom_range(8, 20);
        intro_l = next_len;
        wait_for(2, 3, 200, "leave_result");
        m_level = nlv;
        m_target = ntg;
    endtask

    initial begin
        int oc;
        reset = 1'b1;
        start_key = 1'b0;
        score = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_phase", int'(phase), 0);
        check("rst_level", int'(level), 1);
        check("rst_target", int'(target), BASE);
        check("rst_time_left", int'(time_left), ROUND_S);
        check("rst_enable", int'(enable_5sec), 0);
        check("rst_round_active", int'(round_active), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_win", int'(win), 0);
        reset = 1'b0;
        prev = dut_snap();
        mon_en = 1'b1;

        press_start(5, 20);
        play_round(700, 1, oc);
        play_round(900, 1, oc);
        repeat (4) step();
        press_start($urandom_range(1, 6), $urandom_range(8, 20));
        play_round($urandom_range(650, 2000), 1, oc);
        play_round(1000, 1, oc);
        repeat (3) step();
`ifdef EARLY_CLEAR_EN
        press_start(2, $urandom_range(8, 20));
        play_round(650, 2, oc);
        play_round(300, 1, oc);
        repeat (3) step();
`endif
        for (int g = 0; g < 3; g++) begin
            press_start($urandom_range(1, 6), $urandom_range(8, 20));
            do begin
                play_round($urandom_range(500, 1200), 1, oc);
            end while (oc == 0);
            repeat ($urandom_range(2, 5)) step();
        end

        // Reset in the middle of a level-2 round.
        press_start(2, $urandom_range(8, 20));
        play_round(800, 1, oc);
        exp_q.push_back(model_snap(2, m_level, m_target, ROUND_S));
        score = 16'd0;
        wait_for(0, 2, 200, "reset_play");
        exp_q.push_back(model_snap(0, 1, BASE, 0));
        repeat ($urandom_range(1, 8)) step();
        reset = 1'b1;
        step();
        check("midrst_phase", int'(phase), 0);
        check("midrst_level", int'(level), 1);
        check("midrst_target", int'(target), BASE);
        check("midrst_time_left", int'(time_left), ROUND_S);
        check("midrst_enable", int'(enable_5sec), 0);
        check("midrst_round_active", int'(round_active), 0);
        reset = 1'b0;
        repeat (3) step();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
